tone_gen_array: RTL and testbench



---
 rtl/tone_gen_array.sv | 145 ++++++++++++++
 tb/tb_tone_gen_array.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen_array.sv
// Multi-channel tone/noise generator: prescaled divide-by-N channels, optional pairwise
// linking into double-width dividers, LFSR noise gating and a PWM volume mixer.
module tone_gen_array #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 56,
    localparam int AW      = $clog2(2*NUM_CH+2),
    localparam int MW      = VOL_W + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              clrBar,
    input  logic              wr,
    input  logic              rd,
    input  logic [AW-1:0]     addr,
    input  logic [DIV_W-1:0]  din,
    output logic [DIV_W-1:0]  dout,
    output logic [NUM_CH-1:0] chWave,
    output logic              aud
);
    localparam int NP     = NUM_CH / 2;
    localparam int CW     = VOL_W + 4;
    localparam int XW     = (CW > DIV_W) ? CW : DIV_W;
    localparam int PW     = $clog2(PRESCALE);
    localparam int PAIR_W = 2 * DIV_W;

    logic [DIV_W-1:0]  freq [NUM_CH];
    logic [CW-1:0]     ctrl [NUM_CH];
    logic [NP-1:0]     link;
    logic [NP-1:0]     link_d;
    logic [16:0]       lfsr;
    logic [PW-1:0]     pre;
    logic              tick;
    logic [DIV_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] tog;
    logic [NUM_CH-1:0] nbit;
    logic [NUM_CH-1:0] en;
    logic [MW-1:0]     pwm;
    logic [MW-1:0]     sum;
    logic [XW-1:0]     din_x;
    logic [XW-1:0]     rd_x;

    assign din_x = XW'(din);
    assign tick  = (pre == PW'(PRESCALE-1));

    always_ff @(posedge clk or negedge clrBar) begin
        if (!clrBar) begin
            for (int c = 0; c < NUM_CH; c++) begin
                freq[c] <= '0;
                ctrl[c] <= '0;
            end
            link <= '0;
        end else if (wr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (addr == AW'(2*c))   freq[c] <= din;
                if (addr == AW'(2*c+1)) ctrl[c] <= din_x[CW-1:0];
            end
            if (addr == AW'(2*NUM_CH)) link <= din_x[NP-1:0];
        end
    end

    always_comb begin
        rd_x = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == AW'(2*c))   rd_x = XW'(freq[c]);
            if (addr == AW'(2*c+1)) rd_x = XW'(ctrl[c]);
        end
        if (addr == AW'(2*NUM_CH))   rd_x = XW'(link);
        if (addr == AW'(2*NUM_CH+1)) rd_x = XW'(lfsr[DIV_W-1:0]);
    end

    always_ff @(posedge clk or negedge clrBar) begin
        if (!clrBar) begin
            dout <= '0;
            pre  <= '0;
            lfsr <= '0;
            pwm  <= '0;
            aud  <= 1'b0;
        end else begin
            if (rd) dout <= rd_x[DIV_W-1:0];
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) lfsr <= {lfsr[15:0], ~(lfsr[16] ^ lfsr[11])};
            pwm <= pwm + MW'(1);
            aud <= (pwm < sum);
        end
    end

    // A change of a link bit restarts the whole pair from zero on the following cycle.
    always_ff @(posedge clk or negedge clrBar) begin
        if (!clrBar) begin
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
            tog    <= '0;
            nbit   <= '0;
            link_d <= '0;
        end else begin
            link_d <= link;
            for (int k = 0; k < NP; k++) begin
                if (link[k] != link_d[k]) begin
                    cnt[2*k]   <= '0;
                    cnt[2*k+1] <= '0;
                    tog[2*k]   <= 1'b0;
                    tog[2*k+1] <= 1'b0;
                end else if (link[k]) begin
                    if (tick && en[2*k+1]) begin
                        if ({cnt[2*k+1], cnt[2*k]} == '0) begin
                            {cnt[2*k+1], cnt[2*k]} <= {freq[2*k+1], freq[2*k]};
                            tog[2*k+1]  <= ~tog[2*k+1];
                            nbit[2*k+1] <= lfsr[16];
                        end else begin
                            {cnt[2*k+1], cnt[2*k]} <= {cnt[2*k+1], cnt[2*k]} - PAIR_W'(1);
                        end
                    end
                end else begin
                    for (int b = 0; b < 2; b++) begin
                        if (tick && en[2*k+b]) begin
                            if (cnt[2*k+b] == '0) begin
                                cnt[2*k+b]  <= freq[2*k+b];
                                tog[2*k+b]  <= ~tog[2*k+b];
                                nbit[2*k+b] <= lfsr[16];
                            end else begin
                                cnt[2*k+b] <= cnt[2*k+b] - DIV_W'(1);
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        sum    = '0;
        en     = '0;
        chWave = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            en[c] = ctrl[c][VOL_W+3];
            case (ctrl[c][VOL_W+2:VOL_W+1])
                2'b01:   chWave[c] = tog[c] & nbit[c];
                2'b10:   chWave[c] = nbit[c];
                default: chWave[c] = tog[c];
            endcase
            if ((c % 2 == 0) && link[c/2]) chWave[c] = 1'b0;
            if (chWave[c] || ctrl[c][VOL_W]) sum = sum + MW'(ctrl[c][VOL_W-1:0]);
        end
    end
endmodule

// File: tb/tb_tone_gen_array.sv
// Bench for tone_gen_array: an arithmetic model of the register map, channels, LFSR and
// mixer is compared against the DUT every cycle, plus directed literal checks.
module tb_tone_gen_array;
    localparam int NUM_CH   = 4;
    localparam int DIV_W    = 8;
    localparam int VOL_W    = 4;
    localparam int PRESCALE = 4;
    localparam int AW       = 4;
    localparam int MW       = 6;

    logic              clk = 1'b0;
    logic              clrBar = 1'b0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DIV_W-1:0]  din = '0;
    logic [DIV_W-1:0]  dout;
    logic [NUM_CH-1:0] chWave;
    logic              aud;

    tone_gen_array #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .VOL_W(VOL_W), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .clrBar(clrBar), .wr(wr), .rd(rd), .addr(addr), .din(din),
        .dout(dout), .chWave(chWave), .aud(aud)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_freq [NUM_CH];
    int m_ctrl [NUM_CH];
    int m_cnt  [NUM_CH];
    int m_tog  [NUM_CH];
    int m_s    [NUM_CH];
    int m_glob, m_pglob, m_lfsr, m_pre, m_pwm, m_aud, m_dout;
    bit m_tick;

    function automatic int m_wave(input int c);
        int nsel;
        if ((c % 2 == 0) && (((m_glob >> (c/2)) & 1) == 1)) return 0;
        nsel = (m_ctrl[c] >> 5) & 3;
        if (nsel == 1) return m_tog[c] & m_s[c];
        if (nsel == 2) return m_s[c];
        return m_tog[c];
    endfunction

    function automatic int m_waves();
        int w = 0;
        for (int c = 0; c < NUM_CH; c++) w |= m_wave(c) << c;
        return w;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_wave(c) == 1 || ((m_ctrl[c] >> 4) & 1) == 1) s += m_ctrl[c] & 15;
        return s;
    endfunction

    function automatic int m_read(input int a);
        if (a < 2*NUM_CH) return (a % 2 == 0) ? m_freq[a/2] : m_ctrl[a/2];
        if (a == 2*NUM_CH) return m_glob;
        if (a == 2*NUM_CH+1) return m_lfsr & 255;
        return 0;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_freq[c] = 0; m_ctrl[c] = 0; m_cnt[c] = 0; m_tog[c] = 0; m_s[c] = 0;
        end
        m_glob = 0; m_pglob = 0; m_lfsr = 0; m_pre = 0; m_pwm = 0; m_aud = 0; m_dout = 0;
        m_tick = 0;
    endtask

    task automatic m_step();
        bit t;
        int v, hi, lo, a;
        t = (m_pre == PRESCALE - 1);
        a = int'(addr);
        if (rd) m_dout = m_read(a);
        m_aud = (m_pwm < m_sum()) ? 1 : 0;
        m_pwm = (m_pwm + 1) % (1 << MW);
        for (int k = 0; k < NUM_CH/2; k++) begin
            lo = 2*k; hi = 2*k + 1;
            if ((((m_glob ^ m_pglob) >> k) & 1) == 1) begin
                m_cnt[lo] = 0; m_cnt[hi] = 0; m_tog[lo] = 0; m_tog[hi] = 0;
            end else if (((m_glob >> k) & 1) == 1) begin
                if (t && ((m_ctrl[hi] >> 7) & 1) == 1) begin
                    v = m_cnt[hi] * 256 + m_cnt[lo];
                    if (v == 0) begin
                        v = m_freq[hi] * 256 + m_freq[lo];
                        m_tog[hi] ^= 1;
                        m_s[hi] = (m_lfsr >> 16) & 1;
                    end else v--;
                    m_cnt[hi] = v / 256; m_cnt[lo] = v % 256;
                end
            end else begin
                for (int c = lo; c <= hi; c++)
                    if (t && ((m_ctrl[c] >> 7) & 1) == 1) begin
                        if (m_cnt[c] == 0) begin
                            m_cnt[c] = m_freq[c];
                            m_tog[c] ^= 1;
                            m_s[c] = (m_lfsr >> 16) & 1;
                        end else m_cnt[c]--;
                    end
            end
        end
        if (t) m_lfsr = ((m_lfsr << 1) & 32'h1FFFF) | (1 - (((m_lfsr >> 16) ^ (m_lfsr >> 11)) & 1));
        m_pre = t ? 0 : m_pre + 1;
        m_pglob = m_glob;
        if (wr) begin
            if (a < 2*NUM_CH) begin
                if (a % 2 == 0) m_freq[a/2] = int'(din);
                else m_ctrl[a/2] = int'(din);
            end else if (a == 2*NUM_CH) m_glob = int'(din) & 3;
        end
        m_tick = t;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge clrBar);
            if (!clrBar) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("chWave", 32'(chWave), 32'(m_waves()));
            check("aud", 32'(aud), 32'(m_aud));
            check("dout", 32'(dout), 32'(m_dout));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wr_reg(input int a, input int d);
        wr = 1'b1; addr = AW'(a); din = DIV_W'(d);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input int a, output int v);
        rd = 1'b1; addr = AW'(a);
        @(negedge clk);
        rd = 1'b0;
        v = int'(dout);
    endtask

    task automatic do_reset();
        clrBar = 1'b0;
        @(negedge clk);
        clrBar = 1'b1;
    endtask

    task automatic wait_change(input int ch, input int budget, input string name, output int n);
        logic old;
        old = chWave[ch];
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (chWave[ch] !== old) return;
        end
        check({name, "_timeout"}, 32'(n), 32'(0));
    endtask

    initial begin
        int v, n, hi_cnt;
        logic old;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_aud", 32'(aud), 32'd0);
        check("rst_chwave", 32'(chWave), 32'd0);
        clrBar = 1'b1;
        repeat (9) @(negedge clk);
        rd_reg(9, v);
        check("lfsr_after_2_ticks", 32'(v), 32'd3);

        // Channel 0 plain tone, FREQ=3
        do_reset();
        wr_reg(0, 3);
        wr_reg(1, 8'h80);
        wait_change(0, 100, "ch0_first", n);
        wait_change(0, 100, "ch0_half1", n);
        check("ch0_half_period", 32'(n), 32'd16);
        wait_change(0, 100, "ch0_half2", v);
        check("ch0_full_period", 32'(n + v), 32'd32);

        // Linked pair 0
        do_reset();
        wr_reg(8, 1);
        wr_reg(0, 1);
        wr_reg(2, 0);
        wr_reg(3, 8'h80);
        wait_change(1, 100, "link_first", n);
        wait_change(1, 100, "link_half1", n);
        check("link_half_period", 32'(n), 32'd8);
        wait_change(1, 100, "link_half2", n);
        check("link_half_period2", 32'(n), 32'd8);
        check("link_ch0_low", 32'(chWave[0]), 32'd0);

        // Mixer duty cycle
        do_reset();
        wr_reg(1, 8'h15);
        repeat (4) @(negedge clk);
        hi_cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (aud) hi_cnt++;
        end
        check("aud_duty", 32'(hi_cnt), 32'd5);

        // Noise-only channel follows LFSR every tick
        do_reset();
        wr_reg(0, 0);
        wr_reg(1, 8'hC0);
        repeat (200 * PRESCALE) @(negedge clk);

        // Enable freeze at cnt=2, resume after 10 ticks
        do_reset();
        wr_reg(0, 3);
        wr_reg(1, 8'h80);
        n = 0;
        while (!(m_tick && m_cnt[0] == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("freeze_reach_cnt2", 32'(n < 200), 32'd1);
        wr_reg(1, 8'h00);
        n = 0;
        v = 0;
        while (n < 10 && v < 200) begin
            @(negedge clk);
            v++;
            if (m_tick) n++;
        end
        wr_reg(1, 8'h80);
        old = chWave[0];
        n = 0;
        v = 0;
        while (chWave[0] === old && v < 100) begin
            @(negedge clk);
            v++;
            if (m_tick) n++;
        end
        check("resume_ticks", 32'(n), 32'd3);

        // Register read/write behaviour
        wr_reg(4, 8'hA5);
        rd_reg(4, v);
        check("rd_freq2", 32'(v), 32'hA5);
        wr_reg(3, 8'h9A);
        rd_reg(3, v);
        check("rd_ctrl1", 32'(v), 32'h9A);
        wr_reg(8, 8'hFF);
        rd_reg(8, v);
        check("rd_global_unused0", 32'(v), 32'h3);
        rd_reg(11, v);
        check("rd_out_of_range", 32'(v), 32'h0);
        wr_reg(9, 8'h55);
        rd_reg(9, v);
        wr = 1'b1; rd = 1'b1; addr = 4'd4; din = 8'h3C;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check("rd_wr_same_old", 32'(dout), 32'hA5);
        rd_reg(4, v);
        check("rd_after_wr", 32'(v), 32'h3C);
        repeat (20) @(negedge clk);

        // Reset mid-operation clears immediately
        #3 clrBar = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_aud", 32'(aud), 32'd0);
        check("midrst_chwave", 32'(chWave), 32'd0);
        @(negedge clk);
        clrBar = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
